// File: rtl/roce_pkg.sv
// RoCEv2 TX shared definitions: BTH opcodes, transfer type, packet position
// and the header descriptor record handed to the header builder.
package roce_pkg;

    localparam logic [7:0] OP_WR_FIRST      = 8'h06;
    localparam logic [7:0] OP_WR_MIDDLE     = 8'h07;
    localparam logic [7:0] OP_WR_LAST       = 8'h08;
    localparam logic [7:0] OP_WR_LAST_IMM   = 8'h09;
    localparam logic [7:0] OP_WR_ONLY       = 8'h0A;
    localparam logic [7:0] OP_WR_ONLY_IMM   = 8'h0B;
    localparam logic [7:0] OP_SEND_FIRST    = 8'h00;
    localparam logic [7:0] OP_SEND_MIDDLE   = 8'h01;
    localparam logic [7:0] OP_SEND_LAST     = 8'h02;
    localparam logic [7:0] OP_SEND_LAST_IMM = 8'h03;
    localparam logic [7:0] OP_SEND_ONLY     = 8'h04;
    localparam logic [7:0] OP_SEND_ONLY_IMM = 8'h05;

    typedef enum logic {TX_WRITE = 1'b0, TX_SEND = 1'b1} tx_type_t;

    typedef enum logic [1:0] {POS_FIRST, POS_MIDDLE, POS_LAST, POS_ONLY} pkt_pos_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] psn;
        logic [23:0] loc_qp;
        logic        ack_req;
        logic        reth_en;
        logic [63:0] vaddr;
        logic [31:0] reth_len;
        logic        imm_en;
        logic [31:0] imm;
        logic [12:0] payload_len;
    } hdr_desc_t;

    // Position of a packet inside its transfer from the first/last markers.
    function automatic pkt_pos_t pkt_pos(input logic first, input logic last);
        if (first && last) return POS_ONLY;
        if (first)         return POS_FIRST;
        if (last)          return POS_LAST;
        return POS_MIDDLE;
    endfunction

endpackage

// File: rtl/rdma_tx_opcode_sel.sv
// BTH opcode and optional-header selection for one packet, from the
// transfer type, the packet position and the immediate request flag.
module rdma_tx_opcode_sel
    import roce_pkg::*;
(
    input  tx_type_t   tx_type,
    input  pkt_pos_t   pos,
    input  logic       is_imm,
    output logic [7:0] opcode,
    output logic       reth_en,
    output logic       imm_en,
    output logic       ack_req
);

    // Opcode table lookup; IMM variants exist only for LAST and ONLY.
    always_comb begin
        ack_req = (pos == POS_LAST) || (pos == POS_ONLY);
        imm_en  = is_imm && ack_req;
        reth_en = (tx_type == TX_WRITE) && ((pos == POS_FIRST) || (pos == POS_ONLY));
        opcode  = 8'h00;
        case (pos)
            POS_FIRST:  opcode = (tx_type == TX_WRITE) ? OP_WR_FIRST : OP_SEND_FIRST;
            POS_MIDDLE: opcode = (tx_type == TX_WRITE) ? OP_WR_MIDDLE : OP_SEND_MIDDLE;
            POS_LAST: begin
                if (tx_type == TX_WRITE) opcode = imm_en ? OP_WR_LAST_IMM : OP_WR_LAST;
                else                     opcode = imm_en ? OP_SEND_LAST_IMM : OP_SEND_LAST;
            end
            default: begin
                if (tx_type == TX_WRITE) opcode = imm_en ? OP_WR_ONLY_IMM : OP_WR_ONLY;
                else                     opcode = imm_en ? OP_SEND_ONLY_IMM : OP_SEND_ONLY;
            end
        endcase
    end

endmodule

// File: rtl/rdma_tx_pkt_sequencer.sv
// RoCEv2 TX packet sequencer: one header descriptor per framed packet,
// followed by zero-latency payload pass-through; tracks PSN and remaining
// DMA bytes and pulses status_len_err on a byte-count mismatch.
// Optional build macro RDMA_TX_SEQ_STATS_EN adds packet/transfer counters.
module rdma_tx_pkt_sequencer
    import roce_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PSN_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_wr_req_valid,
    output logic                    s_wr_req_ready,
    input  logic [23:0]             s_wr_req_loc_qp,
    input  logic [31:0]             s_wr_req_dma_length,
    input  logic [63:0]             s_wr_req_addr_offset,
    input  logic                    s_wr_req_is_immediate,
    input  logic [31:0]             s_wr_req_immediate_data,
    input  logic                    s_wr_req_tx_type,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [14:0]             s_axis_tuser,
    output logic                    m_hdr_valid,
    input  logic                    m_hdr_ready,
    output logic [7:0]              m_hdr_opcode,
    output logic [PSN_WIDTH-1:0]    m_hdr_psn,
    output logic [23:0]             m_hdr_loc_qp,
    output logic                    m_hdr_ack_req,
    output logic                    m_hdr_reth_en,
    output logic [63:0]             m_hdr_reth_vaddr,
    output logic [31:0]             m_hdr_reth_len,
    output logic                    m_hdr_imm_en,
    output logic [31:0]             m_hdr_imm,
    output logic [12:0]             m_hdr_payload_len,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic [PSN_WIDTH-1:0]    cfg_psn_init,
    input  logic                    cfg_psn_load,
    output logic                    status_len_err,
    output logic                    status_busy
`ifdef RDMA_TX_SEQ_STATS_EN
    ,
    output logic [31:0]             stat_pkt_count,
    output logic [31:0]             stat_xfer_count
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HDR_LOAD = 2'd1;
    localparam logic [1:0] S_HDR_SEND = 2'd2;
    localparam logic [1:0] S_PAYLOAD  = 2'd3;

    logic [1:0]           state;
    logic [23:0]          req_qp;
    logic [31:0]          req_len;
    logic [63:0]          req_addr;
    logic                 req_is_imm;
    logic [31:0]          req_imm;
    tx_type_t             req_type;
    logic                 first_pkt;
    logic                 last_pkt;
    logic [12:0]          pkt_len;
    logic [PSN_WIDTH-1:0] psn;
    logic signed [32:0]   remaining;
    logic signed [32:0]   rem_next;
    hdr_desc_t            hdr;
    logic [7:0]           sel_opcode;
    logic                 sel_reth, sel_imm, sel_ack;
    logic                 req_fire, tlast_fire;

    assign req_fire   = s_wr_req_valid && s_wr_req_ready;
    assign tlast_fire = (state == S_PAYLOAD) && s_axis_tvalid && s_axis_tready && s_axis_tlast;
    // Underflow shows up as a negative remaining count after subtraction.
    assign rem_next   = remaining - $signed({20'd0, pkt_len});

    rdma_tx_opcode_sel u_opcode_sel (
        .tx_type (req_type),
        .pos     (pkt_pos(first_pkt, s_axis_tuser[1])),
        .is_imm  (req_is_imm),
        .opcode  (sel_opcode),
        .reth_en (sel_reth),
        .imm_en  (sel_imm),
        .ack_req (sel_ack)
    );

    // Transfer FSM: request latch, descriptor build, header handoff, payload tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            psn            <= '0;
            hdr            <= '0;
            status_len_err <= 1'b0;
            req_qp         <= '0;
            req_len        <= '0;
            req_addr       <= '0;
            req_is_imm     <= 1'b0;
            req_imm        <= '0;
            req_type       <= TX_WRITE;
            first_pkt      <= 1'b0;
            last_pkt       <= 1'b0;
            pkt_len        <= '0;
            remaining      <= '0;
        end else begin
            status_len_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_psn_load) psn <= cfg_psn_init;
                    if (req_fire) begin
                        req_qp     <= s_wr_req_loc_qp;
                        req_len    <= s_wr_req_dma_length;
                        req_addr   <= s_wr_req_addr_offset;
                        req_is_imm <= s_wr_req_is_immediate;
                        req_imm    <= s_wr_req_immediate_data;
                        req_type   <= tx_type_t'(s_wr_req_tx_type);
                        remaining  <= $signed({1'b0, s_wr_req_dma_length});
                        first_pkt  <= 1'b1;
                        state      <= S_HDR_LOAD;
                    end
                end
                S_HDR_LOAD: begin
                    if (s_axis_tvalid) begin
                        pkt_len         <= s_axis_tuser[14:2];
                        last_pkt        <= s_axis_tuser[1];
                        hdr.opcode      <= sel_opcode;
                        hdr.psn         <= psn;
                        hdr.loc_qp      <= req_qp;
                        hdr.ack_req     <= sel_ack;
                        hdr.reth_en     <= sel_reth;
                        hdr.vaddr       <= sel_reth ? req_addr : 64'd0;
                        hdr.reth_len    <= sel_reth ? req_len : 32'd0;
                        hdr.imm_en      <= sel_imm;
                        hdr.imm         <= sel_imm ? req_imm : 32'd0;
                        hdr.payload_len <= s_axis_tuser[14:2];
                        state           <= S_HDR_SEND;
                    end
                end
                S_HDR_SEND: begin
                    if (m_hdr_ready) begin
                        psn       <= psn + 1'b1;
                        first_pkt <= 1'b0;
                        state     <= S_PAYLOAD;
                    end
                end
                default: begin
                    if (tlast_fire) begin
                        remaining <= rem_next;
                        if (rem_next[32] || (last_pkt && (rem_next != '0))) status_len_err <= 1'b1;
                        state <= last_pkt ? S_IDLE : S_HDR_LOAD;
                    end
                end
            endcase
        end
    end

`ifdef RDMA_TX_SEQ_STATS_EN
    // Free-running packet and transfer counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_count  <= '0;
            stat_xfer_count <= '0;
        end else begin
            if (m_hdr_valid && m_hdr_ready) stat_pkt_count <= stat_pkt_count + 32'd1;
            if (tlast_fire && last_pkt)     stat_xfer_count <= stat_xfer_count + 32'd1;
        end
    end
`endif

    assign s_wr_req_ready    = (state == S_IDLE) && !rst;
    assign status_busy       = (state != S_IDLE);
    assign m_hdr_valid       = (state == S_HDR_SEND);
    assign m_hdr_opcode      = hdr.opcode;
    assign m_hdr_psn         = hdr.psn;
    assign m_hdr_loc_qp      = hdr.loc_qp;
    assign m_hdr_ack_req     = hdr.ack_req;
    assign m_hdr_reth_en     = hdr.reth_en;
    assign m_hdr_reth_vaddr  = hdr.vaddr;
    assign m_hdr_reth_len    = hdr.reth_len;
    assign m_hdr_imm_en      = hdr.imm_en;
    assign m_hdr_imm         = hdr.imm;
    assign m_hdr_payload_len = hdr.payload_len;
    assign m_axis_tdata      = s_axis_tdata;
    assign m_axis_tkeep      = s_axis_tkeep;
    assign m_axis_tlast      = s_axis_tlast;
    assign m_axis_tuser      = s_axis_tuser[0];
    assign m_axis_tvalid     = (state == S_PAYLOAD) && s_axis_tvalid;
    assign s_axis_tready     = (state == S_PAYLOAD) && m_axis_tready;

endmodule
